// File: rtl/serial_subtractor_pkg.sv
// -----------------------------------------------------------------------------
// sub_pkg
// Shared definitions for the bit-serial subtractor.
//   DEFAULT_WIDTH : default operand/result width in bits
//   state_t       : controller state encoding (IDLE=0, RUN=1, DONE=2)
//   signed_ovf()  : two's-complement overflow decode for a - b
// -----------------------------------------------------------------------------
package sub_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Subtraction overflows only when the operands have opposite signs and the
   // result sign differs from the minuend sign. With same-sign operands the
   // extra borrow-in can at most reach the most negative value, which fits.
   function automatic logic signed_ovf(input logic a_msb,
                                       input logic b_msb,
                                       input logic dif_msb);
      return (a_msb != b_msb) && (dif_msb != a_msb);
   endfunction

endpackage

// File: rtl/serial_subtractor_fs_cell.sv
// -----------------------------------------------------------------------------
// fs_cell
// Combinational 1-bit full subtractor.
//   a       : minuend bit
//   b       : subtrahend bit
//   bor_in  : borrow from the next-lower bit
//   dif     : difference bit, a - b - bor_in
//   bor_out : borrow into the next-higher bit
// -----------------------------------------------------------------------------
module fs_cell (
   input  logic a,
   input  logic b,
   input  logic bor_in,
   output logic dif,
   output logic bor_out
);

   logic a_xor_b;

   assign a_xor_b = a ^ b;
   assign dif     = a_xor_b ^ bor_in;
   // Borrow when b exceeds a outright, or when they are equal and a borrow
   // is already pending from below.
   assign bor_out = (~a & b) | (~a_xor_b & bor_in);

endmodule

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
// Bit-serial subtractor: computes in_a - in_b - in_bor one bit per clock,
// LSB first, through a single fs_cell. Ready/valid handshake on both sides.
//   clk        : clock, all state on rising edge
//   reset      : synchronous active-high reset
//   in_valid   : operand set valid
//   in_ready   : block idle and able to accept operands
//   in_a       : minuend        (WIDTH bits)
//   in_b       : subtrahend     (WIDTH bits)
//   in_bor     : borrow into bit 0
//   out_valid  : result valid
//   out_ready  : consumer takes the result
//   out_dif    : difference modulo 2^WIDTH
//   out_bor    : borrow out of the MSB (unsigned underflow)
//   out_ovf    : signed overflow
//   out_zero   : out_dif is zero
// Timing: accept edge, WIDTH edges of RUN, then DONE until handoff; a new
// operand can be taken every WIDTH+2 edges.
// -----------------------------------------------------------------------------
module serial_subtractor
   import sub_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_bor,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_dif,
   output logic             out_bor,
   output logic             out_ovf,
   output logic             out_zero
);

   localparam int            CW       = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   // Controller and datapath state
   state_t           state_reg;
   logic [CW-1:0]    cnt_reg;
   logic [WIDTH-1:0] a_reg;        // shifts right, current bit in [0]
   logic [WIDTH-1:0] b_reg;
   logic             a_msb_reg;    // operand signs kept for overflow decode
   logic             b_msb_reg;
   logic             bor_reg;      // borrow carried between bits
   logic [WIDTH-1:0] work_reg;     // partial difference, filled from MSB side

   // Result registers, held until the next operation completes
   logic [WIDTH-1:0] dif_reg;
   logic             bor_out_reg;
   logic             ovf_reg;
   logic             zero_reg;

   // Handshake flags, registered alongside the state
   logic             in_ready_reg;
   logic             out_valid_reg;

   // Cell interface and next-value helpers
   logic             cell_dif;
   logic             cell_bor;
   logic [WIDTH-1:0] work_next;
   logic             last_bit;

   fs_cell u_fs_cell (
      .a       (a_reg[0]),
      .b       (b_reg[0]),
      .bor_in  (bor_reg),
      .dif     (cell_dif),
      .bor_out (cell_bor)
   );

   // Each new bit enters at the top; after WIDTH shifts bit 0 of the result
   // has reached position 0, so the word ends up right-aligned.
   assign work_next = {cell_dif, work_reg[WIDTH-1:1]};
   assign last_bit  = (cnt_reg == LAST_BIT);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= IDLE;
         cnt_reg       <= '0;
         a_reg         <= '0;
         b_reg         <= '0;
         a_msb_reg     <= 1'b0;
         b_msb_reg     <= 1'b0;
         bor_reg       <= 1'b0;
         work_reg      <= '0;
         dif_reg       <= '0;
         bor_out_reg   <= 1'b0;
         ovf_reg       <= 1'b0;
         zero_reg      <= 1'b0;
         in_ready_reg  <= 1'b1;
         out_valid_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (in_valid) begin
                  a_reg        <= in_a;
                  b_reg        <= in_b;
                  a_msb_reg    <= in_a[WIDTH-1];
                  b_msb_reg    <= in_b[WIDTH-1];
                  bor_reg      <= in_bor;
                  cnt_reg      <= '0;
                  work_reg     <= '0;
                  state_reg    <= RUN;
                  in_ready_reg <= 1'b0;
               end
            end

            RUN: begin
               a_reg    <= {1'b0, a_reg[WIDTH-1:1]};
               b_reg    <= {1'b0, b_reg[WIDTH-1:1]};
               bor_reg  <= cell_bor;
               work_reg <= work_next;
               cnt_reg  <= cnt_reg + CW'(1);
               if (last_bit) begin
                  // work_next already holds the complete difference here,
                  // and cell_dif is its sign bit.
                  dif_reg       <= work_next;
                  bor_out_reg   <= cell_bor;
                  ovf_reg       <= signed_ovf(a_msb_reg, b_msb_reg, cell_dif);
                  zero_reg      <= ~|work_next;
                  state_reg     <= DONE;
                  out_valid_reg <= 1'b1;
               end
            end

            DONE: begin
               if (out_ready) begin
                  state_reg     <= IDLE;
                  out_valid_reg <= 1'b0;
                  in_ready_reg  <= 1'b1;
               end
            end

            default: begin
               state_reg     <= IDLE;
               out_valid_reg <= 1'b0;
               in_ready_reg  <= 1'b1;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_reg;
   assign out_valid = out_valid_reg;
   assign out_dif   = dif_reg;
   assign out_bor   = bor_out_reg;
   assign out_ovf   = ovf_reg;
   assign out_zero  = zero_reg;

endmodule
